// File: rtl/load_store_unit_pkg.sv
// Shared ALU op codes, FSM state encoding and decode helpers for the load/store unit.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BEAT0,
        LSU_BEAT1,
        LSU_FIN
    } lsu_state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_LOAD,
        OP_STORE
    } lsu_op_t;

    // Byte-lane footprint of the access; zero for codes that are not memory ops.
    function automatic logic [3:0] size_mask(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: size_mask = 4'b0001;
            ALU_LH, ALU_LHU, ALU_SH: size_mask = 4'b0011;
            ALU_LW, ALU_SW:          size_mask = 4'b1111;
            default:                 size_mask = 4'b0000;
        endcase
    endfunction

    // True when the access straddles a word boundary and needs a second beat.
    function automatic logic needs_split(input logic [3:0] mask, input logic [1:0] offset);
        needs_split = ((mask == 4'b0011) && (offset == 2'd3)) ||
                      ((mask == 4'b1111) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  alucode;
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        resp_valid;
    logic [31:0] r_data;

    modport master (
        output req_valid, alucode, is_load, is_store, addr, w_data,
        input  req_ready, resp_valid, r_data
    );

    modport slave (
        input  req_valid, alucode, is_load, is_store, addr, w_data,
        output req_ready, resp_valid, r_data
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store lane mask/data shift and load extract/extend.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [5:0]  alucode,
    input  logic [1:0]  offset,
    input  logic [31:0] w_data,
    input  logic        split,
    input  logic [31:0] lo_buf,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  lane_mask,
    output logic [63:0] st_data,
    output logic [31:0] ld_data
);

    logic [63:0] w64;
    logic [63:0] x;

    // Position store lanes and pull the addressed bytes out of the one- or two-word load window.
    always_comb begin
        lane_mask = {4'b0000, size_mask(alucode)} << offset;
        st_data   = {32'b0, w_data} << {offset, 3'b000};
        w64       = split ? {mem_rdata, lo_buf} : {32'b0, mem_rdata};
        x         = w64 >> {offset, 3'b000};
        case (alucode)
            ALU_LB:  ld_data = {{24{x[7]}}, x[7:0]};
            ALU_LBU: ld_data = {24'b0, x[7:0]};
            ALU_LH:  ld_data = {{16{x[15]}}, x[15:0]};
            ALU_LHU: ld_data = {16'b0, x[15:0]};
            default: ld_data = x[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake, drives a word-addressed
// byte-enabled RAM port, splitting misaligned accesses into two beats.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  lsu,
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    lsu_op_t     op_r;
    logic [5:0]  alu_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] lo_buf;

    logic        split;
    logic [7:0]  lane_mask;
    logic [63:0] st_data;
    logic [31:0] ld_data;
    logic [ADDR_W-1:0] word_idx;
    logic        unused_addr_bits;
    lsu_op_t     req_op;

    lsu_align u_align (
        .alucode   (alu_r),
        .offset    (addr_r[1:0]),
        .w_data    (wdata_r),
        .split     (split),
        .lo_buf    (lo_buf),
        .mem_rdata (mem_rdata),
        .lane_mask (lane_mask),
        .st_data   (st_data),
        .ld_data   (ld_data)
    );

    // Classify the incoming request and derive per-access geometry from the latched one.
    always_comb begin
        req_op = OP_NOP;
        if (size_mask(lsu.alucode) != 4'b0000) begin
            if (lsu.is_load && !lsu.is_store)
                req_op = OP_LOAD;
            else if (lsu.is_store && !lsu.is_load)
                req_op = OP_STORE;
        end
        split            = needs_split(size_mask(alu_r), addr_r[1:0]);
        word_idx         = addr_r[ADDR_W+1:2];
        unused_addr_bits = ^addr_r[31:ADDR_W+2];
        lsu.req_ready    = (state == LSU_IDLE) && !rst;
    end

    // Sequencer: latch request, walk the beats, return the extended load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LSU_IDLE;
            op_r           <= OP_NOP;
            alu_r          <= '0;
            addr_r         <= '0;
            wdata_r        <= '0;
            lo_buf         <= '0;
            lsu.resp_valid <= 1'b0;
            lsu.r_data     <= '0;
        end else begin
            lsu.resp_valid <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (lsu.req_valid) begin
                        op_r    <= req_op;
                        alu_r   <= lsu.alucode;
                        addr_r  <= lsu.addr;
                        wdata_r <= lsu.w_data;
                        state   <= (req_op == OP_NOP) ? LSU_FIN : LSU_BEAT0;
                    end
                end
                LSU_BEAT0: begin
                    state <= split ? LSU_BEAT1 : LSU_FIN;
                end
                LSU_BEAT1: begin
                    if (op_r == OP_LOAD)
                        lo_buf <= mem_rdata;
                    state <= LSU_FIN;
                end
                default: begin
                    if (op_r == OP_LOAD)
                        lsu.r_data <= ld_data;
                    lsu.resp_valid <= 1'b1;
                    state          <= LSU_IDLE;
                end
            endcase
        end
    end

    // RAM port decode from the current beat; strobes are held off while reset is asserted.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            LSU_BEAT0: begin
                mem_addr = word_idx;
                if (op_r == OP_LOAD)
                    mem_re = 1'b1;
                if (op_r == OP_STORE) begin
                    mem_we    = lane_mask[3:0];
                    mem_wdata = st_data[31:0];
                end
            end
            LSU_BEAT1: begin
                mem_addr = word_idx + ADDR_W'(1);
                if (op_r == OP_LOAD)
                    mem_re = 1'b1;
                if (op_r == OP_STORE) begin
                    mem_we    = lane_mask[7:4];
                    mem_wdata = st_data[63:32];
                end
            end
            default: ;
        endcase
        if (rst) begin
            mem_re = 1'b0;
            mem_we = '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte-enabled RAM.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              preload = 1'b1;
    logic              mem_re;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];

    int n_total = 0;
    int n_bad   = 0;

    int                lat;
    logic [3:0]        rec_we   [1:8];
    logic              rec_re   [1:8];
    logic [ADDR_W-1:0] rec_addr [1:8];
    logic [31:0]       rec_wd   [1:8];
    logic [3:0]        seen_we;
    logic              seen_resp;

    load_store_unit_if lsu_bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu       (lsu_bus),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data one cycle after mem_re, per-lane writes.
    always @(posedge clk) begin
        if (preload) begin
            ram[0]           <= 32'h11223344;
            ram[(1<<ADDR_W)-1] <= 32'hAABBCCDD;
        end else begin
            if (mem_re)
                mem_rdata <= ram[mem_addr];
            for (int i = 0; i < 4; i++)
                if (mem_we[i])
                    ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and record the RAM port each cycle until resp_valid (bounded).
    task do_op(input logic [5:0] code, input logic ld, input logic st,
               input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        lsu_bus.req_valid = 1'b1;
        lsu_bus.alucode   = code;
        lsu_bus.is_load   = ld;
        lsu_bus.is_store  = st;
        lsu_bus.addr      = a;
        lsu_bus.w_data    = d;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) lsu_bus.req_valid = 1'b0;
            rec_we[c]   = mem_we;
            rec_re[c]   = mem_re;
            rec_addr[c] = mem_addr;
            rec_wd[c]   = mem_wdata;
            if (lsu_bus.resp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        lsu_bus.req_valid = 1'b0;
        lsu_bus.alucode   = '0;
        lsu_bus.is_load   = 1'b0;
        lsu_bus.is_store  = 1'b0;
        lsu_bus.addr      = '0;
        lsu_bus.w_data    = '0;

        repeat (2) @(negedge clk);
        rst     = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        check_val("rst_ready",  lsu_bus.req_ready, 1);
        check_val("rst_resp",   lsu_bus.resp_valid, 0);
        check_val("rst_rdata",  lsu_bus.r_data, 0);
        check_val("rst_we",     mem_we, 0);
        check_val("rst_re",     mem_re, 0);

        // SW 0x100
        do_op(ALU_SW, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
        check_val("sw_lat",   lat, 3);
        check_val("sw_addr",  rec_addr[1], 15'h40);
        check_val("sw_we",    rec_we[1], 4'b1111);
        check_val("sw_wd",    rec_wd[1], 32'hDEADBEEF);
        check_val("sw_fin_we", rec_we[2], 0);
        @(negedge clk);
        check_val("sw_resp_1cyc", lsu_bus.resp_valid, 0);

        do_op(ALU_LW, 1'b1, 1'b0, 32'h100, 32'h0);
        check_val("lw_lat",  lat, 3);
        check_val("lw_re",   rec_re[1], 1);
        check_val("lw_data", lsu_bus.r_data, 32'hDEADBEEF);

        // SB 0x103 then signed / unsigned byte loads
        do_op(ALU_SB, 1'b0, 1'b1, 32'h103, 32'h80);
        check_val("sb_we",  rec_we[1], 4'b1000);
        check_val("sb_wd",  rec_wd[1], 32'h80000000);
        do_op(ALU_LB, 1'b1, 1'b0, 32'h103, 32'h0);
        check_val("lb_data", lsu_bus.r_data, 32'hFFFFFF80);
        do_op(ALU_LBU, 1'b1, 1'b0, 32'h103, 32'h0);
        check_val("lbu_data", lsu_bus.r_data, 32'h00000080);

        // Split halfword store across words 0x41/0x42
        do_op(ALU_SH, 1'b0, 1'b1, 32'h107, 32'hA5C3);
        check_val("sh_lat",    lat, 4);
        check_val("sh_a0",     rec_addr[1], 15'h41);
        check_val("sh_we0",    rec_we[1], 4'b1000);
        check_val("sh_wd0",    rec_wd[1], 32'hC3000000);
        check_val("sh_a1",     rec_addr[2], 15'h42);
        check_val("sh_we1",    rec_we[2], 4'b0001);
        check_val("sh_wd1",    rec_wd[2], 32'h000000A5);
        check_val("sh_rdata_kept", lsu_bus.r_data, 32'h00000080);

        do_op(ALU_LH, 1'b1, 1'b0, 32'h107, 32'h0);
        check_val("lh_lat",  lat, 4);
        check_val("lh_data", lsu_bus.r_data, 32'hFFFFA5C3);

        // Split word load wrapping from the last word to word 0
        do_op(ALU_LW, 1'b1, 1'b0, 32'h1FFFE, 32'h0);
        check_val("wrap_lat",  lat, 4);
        check_val("wrap_a0",   rec_addr[1], 15'h7FFF);
        check_val("wrap_a1",   rec_addr[2], 15'h0000);
        check_val("wrap_re1",  rec_re[2], 1);
        check_val("wrap_data", lsu_bus.r_data, 32'h3344AABB);

        // Reset during BEAT0 of a split store
        @(negedge clk);
        lsu_bus.req_valid = 1'b1;
        lsu_bus.alucode   = ALU_SW;
        lsu_bus.is_load   = 1'b0;
        lsu_bus.is_store  = 1'b1;
        lsu_bus.addr      = 32'h1FD;
        lsu_bus.w_data    = 32'h12345678;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        check_val("mid_b0_we", mem_we, 4'b1110);
        rst = 1'b1;
        #1;
        check_val("mid_rst_we", mem_we, 0);
        @(negedge clk);
        check_val("mid_rst_ready", lsu_bus.req_ready, 0);
        rst = 1'b0;
        seen_we   = '0;
        seen_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_we   = seen_we | mem_we;
            seen_resp = seen_resp | lsu_bus.resp_valid;
        end
        check_val("mid_no_we",   seen_we, 0);
        check_val("mid_no_resp", seen_resp, 0);
        check_val("mid_idle",    lsu_bus.req_ready, 1);
        check_val("mid_rdata_rst", lsu_bus.r_data, 0);

        // Conflicting qualifiers: nop
        do_op(ALU_LW, 1'b1, 1'b1, 32'h100, 32'h0);
        check_val("nop_lat",  lat, 2);
        check_val("nop_re",   rec_re[1], 0);
        check_val("nop_we",   rec_we[1], 0);
        check_val("nop_addr", rec_addr[1], 0);
        check_val("nop_rdata", lsu_bus.r_data, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit on the CPU side of the data-memory interface. It accepts one load or store per handshake from the execute stage and drives a word-addressed, byte-enabled synchronous RAM port. Misaligned halfword/word accesses are split into two word beats. Load data is returned aligned and sign- or zero-extended. It replaces direct execute-to-RAM wiring and gives the pipeline a stall (`req_ready`) and completion (`resp_valid`) signal.

## Interface
- `ADDR_W`, 15, word-index width of the RAM port (RAM depth is 2^ADDR_W words).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; request is accepted when `req_valid && req_ready`.
- `alucode`  in  6  `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` codes from `define.vh`.
- `is_load`, `is_store`  in  1 each  decoder qualifiers.
- `addr`  in  32  byte address.
- `w_data`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `r_data`  out  32  load result, extended; holds its value between loads.
- `mem_re`  out  1  RAM read strobe; `mem_rdata` is valid the following cycle.
- `mem_we`  out  4  RAM byte-lane write enables.
- `mem_addr`  out  ADDR_W  RAM word index.
- `mem_wdata`  out  32  RAM write data, lane-positioned.
- `mem_rdata`  in  32  RAM read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, FIN.
- IDLE:
  - `req_ready = 1` (forced 0 while `rst` is high).
  - On accept, latch alucode, addr, w_data and the op class, then go to BEAT0.
- Op class:
  - load if `is_load && !is_store`; store if `is_store && !is_load`.
  - Otherwise, or for an alucode not in the list: nop. A nop goes IDLE→FIN with no RAM activity.
- Size mask: B = 4'b0001, H = 4'b0011, W = 4'b1111. Offset `o = addr[1:0]`.
- Split condition:
  - H with `o == 3`, or W with `o != 0`.
  - Byte accesses never split.
- Lane mask `m8 = mask << o` (8 bits). Store data `d64 = {32'b0, w_data} << 8*o`.
- BEAT0:
  - `mem_addr = addr[ADDR_W+1:2]`.
  - Load: `mem_re = 1`.
  - Store: `mem_we = m8[3:0]`, `mem_wdata = d64[31:0]`.
  - Next state: BEAT1 if split, else FIN.
- BEAT1:
  - `mem_addr = addr[ADDR_W+1:2] + 1`, wrapping modulo 2^ADDR_W.
  - Store: `mem_we = m8[7:4]`, `mem_wdata = d64[63:32]`.
  - Load: `mem_re = 1`; capture `mem_rdata` (beat-0 data) into `lo_buf`.
  - Next state: FIN.
- FIN:
  - Load: form `w64` = `{mem_rdata, lo_buf}` if split, else `{32'b0, mem_rdata}`.
  - `x = w64 >> 8*o`.
  - LB/LBU: extend `x[7:0]`. LH/LHU: extend `x[15:0]`, sign from bit 15. LW: `x[31:0]`.
  - On the exiting edge, load `r_data` and set `resp_valid`. Next state: IDLE.
- In every state other than BEAT0/BEAT1: `mem_re = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.

## Timing
- Reset values: state IDLE; `resp_valid = 0`, `r_data = 0`, `lo_buf = 0`. RAM strobes are 0 during and after reset.
- Reset mid-operation:
  - Abandons the access; no `resp_valid`.
  - A beat already written is not undone.
- Accept in cycle N:
  - Non-split: BEAT0 in N+1, FIN in N+2, `resp_valid` in N+3.
  - Split: `resp_valid` in N+4.
  - Nop: FIN in N+1, `resp_valid` in N+2.
- `resp_valid` is high for exactly one cycle. That cycle is the IDLE cycle, so a new request may be accepted in the same cycle.
- Throughput: one non-split access per 3 cycles.
- `req_valid` while not IDLE is ignored; the requester holds it.
- Stores pulse `resp_valid` with `r_data` unchanged.

## Structure
- ALU codes stay in the shared `define.vh`. Add `LSU_IDLE/BEAT0/BEAT1/FIN` state encodings there.
- Sub-module `lsu_align`: purely combinational.
  - Store side: lane mask and data shift.
  - Load side: 64-bit extract and sign/zero extend.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Reset held 2 cycles, then released → `req_ready = 1`, `resp_valid = 0`, `r_data = 0`, `mem_we = 0`.
- SW addr 0x100, data 0xDEADBEEF → one beat, `mem_addr = 0x40`, `mem_we = 4'b1111`, `resp_valid` at N+3. Then LW 0x100 → `r_data = 0xDEADBEEF`.
- SB 0x103, data 0x80 → `mem_we = 4'b1000`, `mem_wdata[31:24] = 0x80`. Then LB 0x103 → `0xFFFFFF80`; LBU 0x103 → `0x00000080`.
- SH 0x107, data 0xA5C3 → beat0 word 0x41 with `we = 1000` and byte 0xC3; beat1 word 0x42 with `we = 0001` and byte 0xA5. Then LH 0x107 → `0xFFFFA5C3` at N+4.
- LW 0x1FFFE (word 0x7FFF, o = 2) → beat1 `mem_addr` wraps to 0; result is `{word0[15:0], word7FFF[31:16]}`.
- `rst` asserted during BEAT0 of a split SW → no BEAT1 write, no `resp_valid`, state IDLE. A request with `is_load = is_store = 1` → no RAM strobes, `resp_valid` at N+2.
